// File: rtl/mult_vec_acc_wrapp.sv
// Multi-lane fixed-point multiplier with per-lane side-channel delay and optional MAC stage.
// Optional saturation-event counter: define MULT_VEC_SAT_CNT_EN to add sat_cnt_clr/sat_cnt.
package mult_vec_pkg;
    typedef enum logic [1:0] {
        FIXED_POINT_GENERIC = 2'd0,
        FIXED_POINT_Q       = 2'd1,
        INTEGER_ARITH       = 2'd2
    } arith_type_t;

    typedef struct packed {
        int unsigned int_wdt;
        int unsigned frac_wdt;
    } arith_fmt_t;

    typedef struct packed {
        int unsigned word_wdt;
        arith_fmt_t  fmt;
        arith_type_t arith_type;
        logic        arith_satur;
    } arith_cfg_t;

    localparam int DATA_W = 16;
    localparam int TYPE_W = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data_word;
        logic              data_val;
        logic [TYPE_W-1:0] data_type;
        logic              data_last;
    } pipe_data_t;
endpackage

// Enable-gated register delay line, LEN stages (LEN=0 is a wire).
// Latency: LEN enabled cycles.
// Backpressure: clk_en=0 freezes every stage.
module del_chain #(
    parameter int WD  = 1,
    parameter int LEN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic [WD-1:0] din,
    output logic [WD-1:0] dout
);
    generate
        if (LEN == 0) begin : g_wire
            assign dout = din;
        end else begin : g_regs
            logic [WD-1:0] q [LEN];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LEN; i++) q[i] <= '0;
                end else if (clk_en) begin
                    q[0] <= din;
                    for (int i = 1; i < LEN; i++) q[i] <= q[i-1];
                end
            end
            assign dout = q[LEN-1];
        end
    endgenerate
endmodule

// Signed fixed-point multiplier: product truncated by frac_wdt, clamped to W bits when saturating.
// Latency: IN_CYC_LEN + OUT_CYC_LEN enabled cycles.
// Backpressure: clk_en=0 holds operands, product and valid in place.
module mult_cell
    import mult_vec_pkg::*;
#(
    parameter arith_cfg_t ARITH_CFG   = '{16, '{8, 8}, FIXED_POINT_GENERIC, 1'b1},
    parameter int         IN_CYC_LEN  = 1,
    parameter int         OUT_CYC_LEN = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic [ARITH_CFG.word_wdt-1:0] a_word,
    input  logic [ARITH_CFG.word_wdt-1:0] b_word,
    input  logic                          in_val,
    output logic [ARITH_CFG.word_wdt-1:0] prod_word,
    output logic                          prod_val
);
    localparam int W    = ARITH_CFG.word_wdt;
    localparam int FRAC = ARITH_CFG.fmt.frac_wdt;
    localparam logic signed [2*W-1:0] FULL_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] FULL_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    logic [2*W:0]          in_q;
    logic signed [2*W-1:0] full;
    logic signed [2*W-1:0] shifted;
    logic [W-1:0]          prod_c;

    del_chain #(.WD(2*W+1), .LEN(IN_CYC_LEN)) u_in (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .din({in_val, a_word, b_word}), .dout(in_q)
    );

    always_comb begin
        full    = $signed(in_q[2*W-1:W]) * $signed(in_q[W-1:0]);
        shifted = full >>> FRAC;
        prod_c  = shifted[W-1:0];
        if (ARITH_CFG.arith_satur) begin
            if (shifted > FULL_MAX)      prod_c = {1'b0, {(W-1){1'b1}}};
            else if (shifted < FULL_MIN) prod_c = {1'b1, {(W-1){1'b0}}};
        end
    end

    del_chain #(.WD(W+1), .LEN(OUT_CYC_LEN)) u_out (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .din({in_q[2*W], prod_c}), .dout({prod_val, prod_word})
    );
endmodule

// NUM_LANES parallel multipliers, each followed by a registered pass-through / accumulate stage.
// Latency: MULT_IN_CYC_LEN + MULT_OUT_CYC_LEN + 1 cycles in both modes.
// Backpressure: none; clk_en=0 freezes every pipeline stage, accumulator and output.
module mult_vec_acc_wrapp
    import mult_vec_pkg::*;
#(
    parameter arith_cfg_t MULT_ARITH_CFG   = '{16, '{8, 8}, FIXED_POINT_GENERIC, 1'b1},
    parameter int         MULT_IN_CYC_LEN  = 1,
    parameter int         MULT_OUT_CYC_LEN = 1,
    parameter int         NUM_LANES        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       acc_mode,
    input  pipe_data_t mult_op_a [NUM_LANES],
    input  pipe_data_t mult_op_b [NUM_LANES],
    output pipe_data_t mult_res  [NUM_LANES]
`ifdef MULT_VEC_SAT_CNT_EN
    ,
    input  logic        sat_cnt_clr,
    output logic [15:0] sat_cnt
`endif
);
    localparam int   W     = MULT_ARITH_CFG.word_wdt;
    localparam int   L     = MULT_IN_CYC_LEN + MULT_OUT_CYC_LEN;
    localparam logic SATUR = MULT_ARITH_CFG.arith_satur;
    localparam logic [W-1:0] SUM_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SUM_MIN = {1'b1, {(W-1){1'b0}}};

`ifdef MULT_VEC_SAT_CNT_EN
    logic [NUM_LANES-1:0] sat_evt;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [W-1:0]        p_word;
            logic                p_val;
            logic [TYPE_W+1:0]   side_q;
            logic                d_last;
            logic                d_mode;
            logic [TYPE_W-1:0]   d_type;
            logic signed [W:0]   sum;
            logic                ovf;
            logic [W-1:0]        sum_sat;
            logic [W-1:0]        acc_q;
            pipe_data_t          res_q;
            logic                unused_a_bits;

            assign unused_a_bits = ^{mult_op_a[gi].data_val, mult_op_a[gi].data_type,
                                     mult_op_a[gi].data_last};

            mult_cell #(
                .ARITH_CFG  (MULT_ARITH_CFG),
                .IN_CYC_LEN (MULT_IN_CYC_LEN),
                .OUT_CYC_LEN(MULT_OUT_CYC_LEN)
            ) u_mult (
                .clk      (clk),
                .rst_n    (rst_n),
                .clk_en   (clk_en),
                .a_word   (mult_op_a[gi].data_word),
                .b_word   (mult_op_b[gi].data_word),
                .in_val   (mult_op_b[gi].data_val),
                .prod_word(p_word),
                .prod_val (p_val)
            );

            // acc_mode travels with its operand so a mode change never retimes in-flight data
            del_chain #(.WD(TYPE_W+2), .LEN(L)) u_side (
                .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
                .din ({mult_op_b[gi].data_last, mult_op_b[gi].data_type, acc_mode}),
                .dout(side_q)
            );
            assign {d_last, d_type, d_mode} = side_q;

            assign sum     = $signed({acc_q[W-1], acc_q}) + $signed({p_word[W-1], p_word});
            assign ovf     = sum[W] ^ sum[W-1];
            assign sum_sat = (SATUR && ovf) ? (sum[W] ? SUM_MIN : SUM_MAX) : sum[W-1:0];

`ifdef MULT_VEC_SAT_CNT_EN
            assign sat_evt[gi] = clk_en & p_val & d_mode & ovf & SATUR;
`endif

            // A valid MULT product also clears acc, dropping any partial sum left by a MAC->MULT flip
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                    res_q <= '0;
                end else if (clk_en) begin
                    res_q.data_val  <= 1'b0;
                    res_q.data_last <= 1'b0;
                    if (p_val) begin
                        if (!d_mode) begin
                            res_q.data_word <= p_word;
                            res_q.data_val  <= 1'b1;
                            res_q.data_last <= d_last;
                            res_q.data_type <= d_type;
                            acc_q           <= '0;
                        end else if (!d_last) begin
                            acc_q <= sum_sat;
                        end else begin
                            res_q.data_word <= sum_sat;
                            res_q.data_val  <= 1'b1;
                            res_q.data_last <= 1'b1;
                            res_q.data_type <= d_type;
                            acc_q           <= '0;
                        end
                    end
                end
            end

            assign mult_res[gi] = res_q;
        end
    endgenerate

`ifdef MULT_VEC_SAT_CNT_EN
    logic [15:0] sat_inc;
    logic [16:0] sat_sum;

    always_comb begin
        sat_inc = '0;
        for (int k = 0; k < NUM_LANES; k++) sat_inc = sat_inc + 16'(sat_evt[k]);
        sat_sum = {1'b0, sat_cnt} + {1'b0, sat_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          sat_cnt <= '0;
        else if (sat_cnt_clr) sat_cnt <= '0;
        else if (clk_en)     sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`endif
endmodule
